// File: rtl/rr_arbiter_burst_if.sv
// rr_arbiter_burst_if: request/grant bundle; master drives requests, slave (arbiter) drives grants
interface rr_arbiter_burst_if #(
  parameter int WIDTH = 4
);
  localparam int ID_W = $clog2(WIDTH);
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] lock;
  logic             grant_ready;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  modport master (output req, lock, grant_ready, input grant, grant_valid, grant_id);
  modport slave  (input req, lock, grant_ready, output grant, grant_valid, grant_id);
endinterface

// File: rtl/rr_arbiter_burst.sv
// rr_arbiter_burst: registered round-robin arbiter with grant hold and burst limit; ports clk, rst, bus (req/lock/grant_ready in, grant/grant_valid/grant_id out)
module rr_arbiter_burst #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic rst,
  rr_arbiter_burst_if.slave bus
);
  localparam int ID_W = $clog2(WIDTH);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state;
  logic [WIDTH-1:0] base, grant, new_base, nxt;
  logic [CNT_W-1:0] cnt;
  logic             beat, g_req, g_lock, burst_end, rel;
  logic [ID_W-1:0]  gid;
  // double the vector so the base-relative search wraps around
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] d, m;
    d = {r, r};
    m = d & (~d + {{WIDTH{1'b0}}, b});
    return m[WIDTH-1:0] | m[2*WIDTH-1:WIDTH];
  endfunction
  always_comb begin
    beat      = |grant & bus.grant_ready;
    g_req     = |(bus.req & grant);
    g_lock    = |(bus.lock & grant);
    // >= so a tenure that ran past the limit under lock ends on the first unlocked beat
    burst_end = MAX_BURST != 0 && beat && int'(cnt) >= MAX_BURST - 1 && !g_lock;
    rel       = state == GRANT && (!g_req || burst_end);
    new_base  = {grant[WIDTH-2:0], grant[WIDTH-1]};
    // on cause (a) req[g] is already low, so the raw vector is already masked
    nxt       = pick(bus.req, state == IDLE ? base : new_base);
  end
  always_comb begin
    gid = '0;
    for (int i = 0; i < WIDTH; i++) gid = grant[i] ? gid | ID_W'(i) : gid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      base  <= WIDTH'(1);
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (|bus.req) begin
        grant <= nxt;
        cnt   <= '0;
        state <= GRANT;
      end
    end else if (rel) begin
      base  <= new_base;
      grant <= nxt;
      cnt   <= '0;
      state <= |nxt ? GRANT : IDLE;
    end else if (beat && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end
  assign bus.grant       = grant;
  assign bus.grant_valid = |grant;
  assign bus.grant_id    = gid;
endmodule

// File: tb/tb_rr_arbiter_burst.sv
// tb_rr_arbiter_burst: randomized and directed stimulus checked by a queued scoreboard against a tenure-level model
module tb_rr_arbiter_burst;
  localparam int W  = 4;
  localparam int MB = 2;
  localparam int SAT = 255;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   exp_q[$];
  int   m_owner, m_base, m_beats, mon_o;
  logic [W-1:0] mon_g;
  rr_arbiter_burst_if #(.WIDTH(W)) bus ();
  rr_arbiter_burst #(.WIDTH(W), .MAX_BURST(MB), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int search(input logic [W-1:0] r, input int b);
    for (int k = 0; k < W; k++) if (r[(b + k) % W]) return (b + k) % W;
    return -1;
  endfunction
  task automatic model(input logic r, input logic [W-1:0] q, input logic [W-1:0] l, input logic rdy);
    if (r) begin
      m_owner = -1; m_base = 0; m_beats = 0;
    end else if (m_owner < 0) begin
      m_owner = search(q, m_base); m_beats = 0;
    end else if (!q[m_owner] || (rdy && m_beats + 1 >= MB && !l[m_owner])) begin
      m_base  = (m_owner + 1) % W;
      m_owner = search(q, m_base);
      m_beats = 0;
    end else if (rdy && m_beats < SAT) begin
      m_beats++;
    end
  endtask
  task automatic step(input logic r, input logic [W-1:0] q, input logic [W-1:0] l, input logic rdy);
    rst = r; bus.req = q; bus.lock = l; bus.grant_ready = rdy;
    model(r, q, l, rdy);
    @(posedge clk);
    exp_q.push_back(m_owner);
    #1;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_o = exp_q.pop_front();
      mon_g = mon_o < 0 ? '0 : W'(1) << mon_o;
      checks++;
      if (bus.grant !== mon_g || bus.grant_valid !== (mon_o >= 0) || bus.grant_id !== (mon_o < 0 ? 2'd0 : 2'(mon_o))) begin
        failures++;
        $display("FAIL grant t=%0t got grant=%b valid=%b id=%0d want grant=%b valid=%b id=%0d",
                 $time, bus.grant, bus.grant_valid, bus.grant_id, mon_g, mon_o >= 0, mon_o < 0 ? 0 : mon_o);
      end
    end
  end
  initial begin
    logic [W-1:0] q;
    m_owner = -1; m_base = 0; m_beats = 0;
    repeat (2) step(1, 4'b0000, 4'b0000, 1);
    repeat (5) step(0, 4'b0000, 4'b0000, 1);
    repeat (9) step(0, 4'b1111, 4'b0000, 1);
    step(1, 4'b0000, 4'b0000, 1);
    step(0, 4'b0101, 4'b0000, 0);
    repeat (3) step(0, 4'b0101, 4'b0000, 0);
    repeat (3) step(0, 4'b0101, 4'b0000, 1);
    step(1, 4'b0000, 4'b0000, 1);
    step(0, 4'b0010, 4'b0010, 1);
    repeat (6) step(0, 4'b0011, 4'b0010, 1);
    repeat (3) step(0, 4'b0011, 4'b0000, 1);
    step(1, 4'b0000, 4'b0000, 1);
    step(0, 4'b0100, 4'b0000, 1);
    step(0, 4'b0100, 4'b0000, 1);
    repeat (3) step(0, 4'b0000, 4'b0000, 1);
    repeat (3) step(0, 4'b1001, 4'b0000, 1);
    repeat (3) step(0, 4'b1111, 4'b0000, 1);
    step(1, 4'b1111, 4'b0000, 1);
    repeat (3) step(0, 4'b1111, 4'b0000, 1);
    step(1, 4'b0000, 4'b0000, 1);
    step(0, 4'b0010, 4'b0010, 1);
    repeat (256) step(0, 4'b0011, 4'b0010, 1);
    repeat (3) step(0, 4'b0011, 4'b0000, 1);
    q = 4'($urandom);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0) q = 4'($urandom);
      step($urandom_range(0, 99) == 0, q, $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'b0000, $urandom_range(0, 3) != 0);
    end
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
